// File: rtl/result_to_seg.sv
// Binary result to packed 7-segment codes via sequential double-dabble, with leading-zero blanking.
// Optional feature: define NEG_SIGN_EN for two's-complement input with a leading '-' sign.
module result_to_seg #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     value,
  output logic                  busy,
  output logic                  done,
  output logic [8*DIGITS-1:0]   seg,
  output logic [7:0]            num
);

`ifdef NEG_SIGN_EN
  // One extra magnitude bit so the most negative input still has a representable magnitude.
  localparam int MAG_W = DATA_W + 1;
`else
  localparam int MAG_W = DATA_W;
`endif
  localparam int CNT_W = $clog2(MAG_W + 1);

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned MAX_POS = pow10(DIGITS) - 1;
`ifdef NEG_SIGN_EN
  localparam longint unsigned MAX_NEG = pow10(DIGITS - 1) - 1;
`endif

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h3F;
      4'd1:    return 8'h06;
      4'd2:    return 8'h5B;
      4'd3:    return 8'h4F;
      4'd4:    return 8'h66;
      4'd5:    return 8'h6D;
      4'd6:    return 8'h7D;
      4'd7:    return 8'h07;
      4'd8:    return 8'h7F;
      4'd9:    return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ENCODE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   val_q;
  logic [MAG_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_q;
`ifdef NEG_SIGN_EN
  logic                neg_q;
`endif

  logic [MAG_W-1:0]    mag;
  logic                is_ovf;
  logic [4*DIGITS-1:0] adj;
  logic [8*DIGITS-1:0] seg_next;
  logic [7:0]          num_next;
  int                  msd;

  always_comb begin
`ifdef NEG_SIGN_EN
    mag    = val_q[DATA_W-1] ? -{1'b1, val_q} : {1'b0, val_q};
    is_ovf = val_q[DATA_W-1] ? (64'(mag) > MAX_NEG) : (64'(mag) > MAX_POS);
`else
    mag    = val_q;
    is_ovf = 64'(mag) > MAX_POS;
`endif
  end

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  // Digits above the most significant nonzero one stay blank; an all-zero value still shows '0'.
  always_comb begin
    seg_next = '0;
    num_next = '0;
    msd      = 0;
    for (int k = 0; k < DIGITS; k++)
      if (bcd_q[4*k +: 4] != 4'd0) msd = k;
    for (int k = 0; k < DIGITS; k++)
      if (k <= msd) seg_next[8*k +: 8] = seg_code(bcd_q[4*k +: 4]);
    num_next = 8'(msd);
`ifdef NEG_SIGN_EN
    if (neg_q && msd < DIGITS - 1) begin
      seg_next[8*(msd+1) +: 8] = 8'h40;
      num_next                 = 8'(msd + 1);
    end
`endif
    if (ovf_q) begin
      seg_next        = '0;
      seg_next[23:0]  = 24'h795050;
      num_next        = 8'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      seg   <= '0;
      num   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      val_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
`ifdef NEG_SIGN_EN
      neg_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            val_q <= value;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          ovf_q <= is_ovf;
`ifdef NEG_SIGN_EN
          neg_q <= val_q[DATA_W-1];
`endif
          bcd_q <= '0;
          bin_q <= mag;
          cnt_q <= CNT_W'(MAG_W);
          state <= is_ovf ? ENCODE : SHIFT;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {adj, bin_q} << 1;
          cnt_q          <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state <= ENCODE;
        end
        ENCODE: begin
          seg   <= seg_next;
          num   <= num_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_to_seg.sv
// Directed bench for result_to_seg: conversion results, latency, start handling and reset abort.
// Follows NEG_SIGN_EN the same way the design does.
module tb_result_to_seg;

`ifdef NEG_SIGN_EN
  localparam int LAT_N = 17;
`else
  localparam int LAT_N = 16;
`endif
  localparam int LAT_OVF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] value;
  logic        busy;
  logic        done;
  logic [31:0] seg;
  logic [7:0]  num;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  result_to_seg #(.DIGITS(4), .DATA_W(14)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (value),
    .busy  (busy),
    .done  (done),
    .seg   (seg),
    .num   (num)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Pulses start for one edge (E0) and returns the edge index after which done was seen, -1 on timeout.
  task automatic applyStimulus(input logic [13:0] v, input int repulse_at, output int lat_o);
    int n;
    @(negedge clk);
    value = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    lat_o = -1;
    checkOutput("busy_after_accept", 64'(busy), 64'd1);
    while (n < 40 && lat_o < 0) begin
      start = (repulse_at == n + 1);
      @(negedge clk);
      n++;
      if (done) lat_o = n;
    end
    start = 1'b0;
    checkOutput("busy_at_done", 64'(busy), 64'd0);
  endtask

  task automatic expectNoDone(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput(tag, 64'(cnt), 64'd0);
  endtask

  initial begin
    int dones;
    int last_at;
    int gap_bad;
    rst   = 1'b0;
    start = 1'b0;
    value = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_seg",  64'(seg),  64'd0);
    checkOutput("rst_num",  64'(num),  64'd0);
    rst = 1'b1;

    applyStimulus(14'd1234, -1, lat);
    checkOutput("t1_lat", 64'(lat), 64'(LAT_N));
    checkOutput("t1_seg", 64'(seg), 64'h065B4F66);
    checkOutput("t1_num", 64'(num), 64'd3);
    @(negedge clk);
    checkOutput("t1_done_pulse", 64'(done), 64'd0);
    checkOutput("t1_seg_hold",   64'(seg),  64'h065B4F66);

    applyStimulus(14'd0, -1, lat);
    checkOutput("t2_zero_seg", 64'(seg), 64'h0000003F);
    checkOutput("t2_zero_num", 64'(num), 64'd0);
    applyStimulus(14'd7, -1, lat);
    checkOutput("t2_seven_seg", 64'(seg), 64'h00000007);
    checkOutput("t2_seven_num", 64'(num), 64'd0);
    applyStimulus(14'd1005, -1, lat);
    checkOutput("t2_1005_seg", 64'(seg), 64'h063F3F6D);
    checkOutput("t2_1005_num", 64'(num), 64'd3);

    applyStimulus(14'd10000, -1, lat);
    checkOutput("t3_ovf_lat", 64'(lat), 64'(LAT_OVF));
    checkOutput("t3_ovf_seg", 64'(seg), 64'h00795050);
    checkOutput("t3_ovf_num", 64'(num), 64'd2);
    applyStimulus(14'd9999, -1, lat);
    checkOutput("t3_max_seg", 64'(seg), 64'h6F6F6F6F);
    checkOutput("t3_max_num", 64'(num), 64'd3);

    applyStimulus(14'd1234, 5, lat);
    checkOutput("t4_repulse_lat", 64'(lat), 64'(LAT_N));
    checkOutput("t4_repulse_seg", 64'(seg), 64'h065B4F66);
    expectNoDone("t4_repulse_extra_done", 25);

    // Held start: each done is followed by one IDLE accept edge, so pulses are LAT_N+1 apart.
    @(negedge clk);
    value   = 14'd50;
    start   = 1'b1;
    dones   = 0;
    last_at = -1;
    gap_bad = 0;
    for (int c = 1; c <= 100 && dones < 3; c++) begin
      @(negedge clk);
      if (done) begin
        if (last_at >= 0 && c - last_at != LAT_N + 1) gap_bad++;
        last_at = c;
        dones++;
      end
    end
    start = 1'b0;
    checkOutput("t4_held_dones", 64'(dones),   64'd3);
    checkOutput("t4_held_gap",   64'(gap_bad), 64'd0);
    checkOutput("t4_held_seg",   64'(seg),     64'h00006D3F);
    checkOutput("t4_held_num",   64'(num),     64'd1);
    expectNoDone("t4_held_extra_done", 25);

    @(negedge clk);
    value = 14'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_done", 64'(done), 64'd0);
    checkOutput("t5_seg",  64'(seg),  64'd0);
    checkOutput("t5_num",  64'(num),  64'd0);
    rst = 1'b1;
    expectNoDone("t5_no_done", 25);

`ifdef NEG_SIGN_EN
    applyStimulus(14'(-7), -1, lat);
    checkOutput("t6_m7_lat", 64'(lat), 64'(LAT_N));
    checkOutput("t6_m7_seg", 64'(seg), 64'h00004007);
    checkOutput("t6_m7_num", 64'(num), 64'd1);
    applyStimulus(14'(-1000), -1, lat);
    checkOutput("t6_m1000_lat", 64'(lat), 64'(LAT_OVF));
    checkOutput("t6_m1000_seg", 64'(seg), 64'h00795050);
    checkOutput("t6_m1000_num", 64'(num), 64'd2);
    applyStimulus(14'(-999), -1, lat);
    checkOutput("t6_m999_seg", 64'(seg), 64'h406F6F6F);
    checkOutput("t6_m999_num", 64'(num), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
